mfcc_window_buffer: RTL and testbench

- Sits directly downstream of the MFCC accelerator and collects its per-frame feature vectors (mfcc_out/mfcc_valid) into a sliding time window.
- Once the window is full, and then every STRIDE new frames, it streams the whole NUM_FRAMES x MFCC_FEATURES feature map to the keyword-spotting CNN input.
- Output is one activation per beat, oldest frame first, over a valid/ready handshake.

---
 rtl/mfcc_pkg.sv | 19 +
 rtl/mfcc_slot_ram.sv | 42 ++++
 rtl/mfcc_window_buffer.sv | 157 +++++++++++++++
 tb/tb_mfcc_window_buffer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mfcc_pkg.sv
// rtl/mfcc_pkg.sv - shared constants, state encoding and slot helper for the MFCC window buffer
package mfcc_pkg;

    localparam int MFCC_FEATURES_DEF = 40;
    localparam int ACTIV_BITS_DEF    = 8;
    localparam int NUM_FRAMES_DEF    = 49;
    localparam int STRIDE_DEF        = 1;
    localparam int SLOTS_DEF         = NUM_FRAMES_DEF + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } win_state_e;

    function automatic int slot_inc(input int idx, input int slots);
        return (idx + 1 >= slots) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mfcc_slot_ram.sv
// rtl/mfcc_slot_ram.sv - frame slot storage, full-vector write, registered single-coefficient read
module mfcc_slot_ram
    import mfcc_pkg::*;
#(
    parameter int SLOTS         = SLOTS_DEF,
    parameter int MFCC_FEATURES = MFCC_FEATURES_DEF,
    parameter int ACTIV_BITS    = ACTIV_BITS_DEF,
    localparam int PW = $clog2(SLOTS),
    localparam int CW = (MFCC_FEATURES > 1) ? $clog2(MFCC_FEATURES) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [PW-1:0]                     wr_slot,
    input  logic [MFCC_FEATURES*ACTIV_BITS-1:0] wr_data,
    input  logic                              rd_en,
    input  logic [PW-1:0]                     rd_slot,
    input  logic [CW-1:0]                     rd_coeff,
    output logic [ACTIV_BITS-1:0]             rd_data
);

    logic [MFCC_FEATURES*ACTIV_BITS-1:0] r_mem [SLOTS];
    logic [ACTIV_BITS-1:0]               r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_slot] <= wr_data;
        end
    end

    // Read register doubles as the output register, so it holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_slot][rd_coeff*ACTIV_BITS +: ACTIV_BITS];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/mfcc_window_buffer.sv
// rtl/mfcc_window_buffer.sv - sliding window of MFCC frames streamed to the KWS CNN input
module mfcc_window_buffer
    import mfcc_pkg::*;
#(
    parameter int MFCC_FEATURES = MFCC_FEATURES_DEF,
    parameter int ACTIV_BITS    = ACTIV_BITS_DEF,
    parameter int NUM_FRAMES    = NUM_FRAMES_DEF,
    parameter int STRIDE        = STRIDE_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [MFCC_FEATURES*ACTIV_BITS-1:0] mfcc_in,
    input  logic                                mfcc_valid,
    input  logic                                clear,
    output logic [ACTIV_BITS-1:0]               feat_out,
    output logic                                feat_valid,
    input  logic                                feat_ready,
    output logic                                feat_first,
    output logic                                feat_last,
    output logic [7:0]                          frames_buffered,
    output logic                                overrun
);

    localparam int SLOTS = NUM_FRAMES + 1;
    localparam int PW    = $clog2(SLOTS);
    localparam int FW    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int CW    = (MFCC_FEATURES > 1) ? $clog2(MFCC_FEATURES) : 1;
    localparam int NW    = $clog2(NUM_FRAMES + 1);

    win_state_e    r_state, w_state_nxt;
    logic [PW-1:0] r_wr_ptr, r_rd_slot;
    logic [FW-1:0] r_frame_idx;
    logic [CW-1:0] r_coeff_idx;
    logic [NW-1:0] r_fill, r_new_cnt;
    logic          r_first_pending, r_valid, r_first, r_last, r_overrun;

    logic          w_accept, w_drop, w_start, w_xfer, w_coeff_wrap, w_rd_en, w_next_last;
    logic [PW-1:0] w_start_base, w_next_slot, w_rd_slot;
    logic [FW-1:0] w_next_frame;
    logic [CW-1:0] w_next_coeff, w_rd_coeff;

    // While streaming, only the spare slot is free, so at most one new frame fits.
    assign w_accept = mfcc_valid & ~clear & ((r_state == IDLE) | (r_new_cnt == '0));
    assign w_drop   = mfcc_valid & ~clear & (r_state == STREAM) & (r_new_cnt != '0);
    assign w_start  = ~clear & (r_state == IDLE) & (r_fill == NW'(NUM_FRAMES))
                    & (r_first_pending | (r_new_cnt >= NW'(STRIDE)));
    assign w_xfer   = r_valid & feat_ready & ~clear;

    assign w_start_base = (r_wr_ptr >= PW'(NUM_FRAMES)) ? r_wr_ptr - PW'(NUM_FRAMES)
                                                        : r_wr_ptr + PW'(SLOTS - NUM_FRAMES);

    assign w_coeff_wrap = (r_coeff_idx == CW'(MFCC_FEATURES - 1));
    assign w_next_coeff = w_coeff_wrap ? '0 : r_coeff_idx + 1'b1;
    assign w_next_frame = w_coeff_wrap ? r_frame_idx + 1'b1 : r_frame_idx;
    assign w_next_slot  = w_coeff_wrap ? PW'(slot_inc(int'(r_rd_slot), SLOTS)) : r_rd_slot;
    assign w_next_last  = (w_next_frame == FW'(NUM_FRAMES - 1))
                        & (w_next_coeff == CW'(MFCC_FEATURES - 1));

    assign w_rd_en    = w_start | (w_xfer & ~r_last);
    assign w_rd_slot  = w_start ? w_start_base : w_next_slot;
    assign w_rd_coeff = w_start ? '0 : w_next_coeff;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = STREAM;
            STREAM:  if (w_xfer && r_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (clear) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr        <= '0;
            r_rd_slot       <= '0;
            r_frame_idx     <= '0;
            r_coeff_idx     <= '0;
            r_fill          <= '0;
            r_new_cnt       <= '0;
            r_first_pending <= 1'b1;
            r_valid         <= 1'b0;
            r_first         <= 1'b0;
            r_last          <= 1'b0;
            r_overrun       <= 1'b0;
        end else if (clear) begin
            r_wr_ptr        <= '0;
            r_fill          <= '0;
            r_new_cnt       <= '0;
            r_first_pending <= 1'b1;
            r_valid         <= 1'b0;
            r_first         <= 1'b0;
            r_last          <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= PW'(slot_inc(int'(r_wr_ptr), SLOTS));
                if (r_fill != NW'(NUM_FRAMES)) r_fill <= r_fill + 1'b1;
            end
            // A frame arriving with the start decision lands in the spare slot and counts toward the next window.
            if (w_start) begin
                r_new_cnt <= w_accept ? NW'(1) : '0;
            end else if (w_accept && r_new_cnt != NW'(NUM_FRAMES)) begin
                r_new_cnt <= r_new_cnt + 1'b1;
            end
            if (w_drop) r_overrun <= 1'b1;
            if (w_start) begin
                r_first_pending <= 1'b0;
                r_valid         <= 1'b1;
                r_first         <= 1'b1;
                r_last          <= (NUM_FRAMES == 1) && (MFCC_FEATURES == 1);
                r_frame_idx     <= '0;
                r_coeff_idx     <= '0;
                r_rd_slot       <= w_start_base;
            end else if (w_xfer) begin
                r_first <= 1'b0;
                if (r_last) begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                end else begin
                    r_frame_idx <= w_next_frame;
                    r_coeff_idx <= w_next_coeff;
                    r_rd_slot   <= w_next_slot;
                    r_last      <= w_next_last;
                end
            end
        end
    end

    mfcc_slot_ram #(
        .SLOTS         (SLOTS),
        .MFCC_FEATURES (MFCC_FEATURES),
        .ACTIV_BITS    (ACTIV_BITS)
    ) u_slot_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (w_accept),
        .wr_slot  (r_wr_ptr),
        .wr_data  (mfcc_in),
        .rd_en    (w_rd_en),
        .rd_slot  (w_rd_slot),
        .rd_coeff (w_rd_coeff),
        .rd_data  (feat_out)
    );

    assign feat_valid      = r_valid;
    assign feat_first      = r_first;
    assign feat_last       = r_last;
    assign frames_buffered = 8'(r_fill);
    assign overrun         = r_overrun;

endmodule

// File: tb/tb_mfcc_window_buffer.sv
// tb/tb_mfcc_window_buffer.sv - directed bench for mfcc_window_buffer (F=4, B=8, N=3, S=1 and S=2)
module tb_mfcc_window_buffer;

    logic        clk, rst_n, mfcc_valid, clear, feat_ready;
    logic [31:0] mfcc_in;
    logic [7:0]  a_out, b_out, a_fb, b_fb;
    logic        a_valid, a_first, a_last, a_overrun;
    logic        b_valid, b_first, b_last, b_overrun;
    int          n_checks = 0;
    int          n_fail   = 0;

    mfcc_window_buffer #(.MFCC_FEATURES(4), .ACTIV_BITS(8), .NUM_FRAMES(3), .STRIDE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .mfcc_in(mfcc_in), .mfcc_valid(mfcc_valid), .clear(clear),
        .feat_out(a_out), .feat_valid(a_valid), .feat_ready(feat_ready), .feat_first(a_first),
        .feat_last(a_last), .frames_buffered(a_fb), .overrun(a_overrun)
    );

    mfcc_window_buffer #(.MFCC_FEATURES(4), .ACTIV_BITS(8), .NUM_FRAMES(3), .STRIDE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .mfcc_in(mfcc_in), .mfcc_valid(mfcc_valid), .clear(clear),
        .feat_out(b_out), .feat_valid(b_valid), .feat_ready(feat_ready), .feat_first(b_first),
        .feat_last(b_last), .frames_buffered(b_fb), .overrun(b_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] frame_vec(input int j);
        logic [31:0] v;
        for (int k = 0; k < 4; k++) v[k*8 +: 8] = 8'(16*j + k);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int j);
        mfcc_in    = frame_vec(j);
        mfcc_valid = 1'b1;
        step();
        mfcc_valid = 1'b0;
    endtask

    // Collect one 12-beat window from dut_a; optionally toggle ready and inject frames at given cycles.
    task automatic collect(input string tag, input int fa, input int fb, input int fc, input bit toggle,
                           input int p1_cyc, input int p1_frame, input int p2_cyc, input int p2_frame);
        int          beats = 0;
        int          cyc   = 0;
        int          fr;
        bit          hold_chk = 1'b0;
        logic [9:0]  held = '0;
        while (beats < 12 && cyc < 200) begin
            mfcc_valid = 1'b0;
            if (cyc == p1_cyc) begin mfcc_in = frame_vec(p1_frame); mfcc_valid = 1'b1; end
            if (cyc == p2_cyc) begin mfcc_in = frame_vec(p2_frame); mfcc_valid = 1'b1; end
            feat_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (hold_chk) check_eq({tag, "_hold"}, {22'b0, a_first, a_last, a_out}, {22'b0, held});
            hold_chk = 1'b0;
            if (a_valid) begin
                if (feat_ready) begin
                    fr = (beats / 4 == 0) ? fa : (beats / 4 == 1) ? fb : fc;
                    check_eq({tag, "_data"}, {24'b0, a_out}, 32'(16*fr + beats % 4));
                    check_eq({tag, "_first"}, {31'b0, a_first}, {31'b0, beats == 0});
                    check_eq({tag, "_last"}, {31'b0, a_last}, {31'b0, beats == 11});
                    beats++;
                end else begin
                    held     = {a_first, a_last, a_out};
                    hold_chk = 1'b1;
                end
            end
            step();
            cyc++;
        end
        mfcc_valid = 1'b0;
        feat_ready = 1'b1;
        check_eq({tag, "_beats"}, 32'(beats), 32'd12);
        check_eq({tag, "_done_valid"}, {31'b0, a_valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; mfcc_valid = 1'b0; clear = 1'b0; feat_ready = 1'b1; mfcc_in = '0;
        #12;
        check_eq("reset_outputs", {12'b0, a_valid, a_first, a_last, a_overrun, a_out, a_fb}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        step();

        // First window: latency check, then full stream.
        push(0); push(1); push(2);
        check_eq("w1_not_yet", {31'b0, a_valid}, 32'd0);
        check_eq("w1_fill", {24'b0, a_fb}, 32'd3);
        step();
        check_eq("w1_valid_rise", {31'b0, a_valid}, 32'd1);
        collect("w1", 0, 1, 2, 1'b0, -1, 0, -1, 0);

        // Slide by one; the S=2 instance must stay idle.
        push(3);
        step();
        check_eq("w2_fill", {24'b0, a_fb}, 32'd3);
        check_eq("s2_no_window", {31'b0, b_valid}, 32'd0);
        collect("w2", 1, 2, 3, 1'b0, -1, 0, -1, 0);

        // Second new frame: both instances start window f2,f3,f4 together.
        push(4);
        step();
        check_eq("s2_window_start", {23'b0, b_valid, b_first, b_out}, {23'b0, 1'b1, 1'b1, 8'd32});
        collect("w3_toggle", 2, 3, 4, 1'b1, 3, 5, 6, 6);
        check_eq("overrun_set", {31'b0, a_overrun}, 32'd1);
        collect("w4", 3, 4, 5, 1'b0, -1, 0, -1, 0);
        check_eq("s2_overrun", {31'b0, b_overrun}, 32'd1);
        check_eq("s2_idle", {31'b0, b_valid}, 32'd0);

        // Clear mid-stream.
        push(7);
        repeat (4) step();
        check_eq("pre_clear_valid", {31'b0, a_valid}, 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_eq("clear_state", {22'b0, a_valid, a_overrun, a_fb}, 32'd0);
        push(8); push(9); push(10);
        collect("post_clear", 8, 9, 10, 1'b0, -1, 0, -1, 0);

        // Asynchronous reset mid-stream.
        push(11);
        repeat (3) step();
        rst_n = 1'b0;
        #2;
        check_eq("midstream_reset", {12'b0, a_valid, a_first, a_last, a_overrun, a_out, a_fb}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        step();

        // Ten frames after reset: wr_ptr wraps SLOTS=4 more than once.
        for (int j = 0; j < 10; j++) begin
            push(j);
            if (j >= 2) collect("wrap", j - 2, j - 1, j, 1'b0, -1, 0, -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
